// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Memory-access stage of the MIPS pipeline. Accepts the execute
//               stage bundle, runs lw/sw/lb/lbu/sb over a req/ack data-memory
//               bus with alignment checking and an ack timeout, and produces a
//               registered write-back bundle. Holds upstream while busy.
// Ports       : clk, rst                  - clock, sync active-high reset
//               ex_valid, op, memAddr,     - execute-stage bundle in
//               memData, regcData,
//               regcAddr, regcWrite
//               stall_o                    - upstream hold
//               dm_req/we/addr/be/wdata,   - data-memory bus
//               dm_ack, dm_rdata
//               wb_valid, wb_regcData,     - write-back bundle out
//               wb_regcAddr, wb_regcWrite
//               misalign_exc, bus_err,     - fault pulses and faulting address
//               exc_addr
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
  parameter logic [5:0] OP_LW   = 6'b100011,
  parameter logic [5:0] OP_SW   = 6'b101011,
  parameter logic [5:0] OP_LB   = 6'b100000,
  parameter logic [5:0] OP_LBU  = 6'b100100,
  parameter logic [5:0] OP_SB   = 6'b101000,
  parameter int         TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [5:0]  op,
  input  logic [31:0] memAddr,
  input  logic [31:0] memData,
  input  logic [31:0] regcData,
  input  logic [4:0]  regcAddr,
  input  logic        regcWrite,
  output logic        stall_o,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_regcData,
  output logic [4:0]  wb_regcAddr,
  output logic        wb_regcWrite,
  output logic        misalign_exc,
  output logic        bus_err,
  output logic [31:0] exc_addr
);

  localparam int              CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [5:0]        op_q, op_d;
  logic [31:0]       addr_q, addr_d;
  logic [4:0]        rdst_q, rdst_d;
  logic              rwe_q, rwe_d;
  logic              dm_req_q, dm_req_d;
  logic              dm_we_q, dm_we_d;
  logic [31:0]       dm_addr_q, dm_addr_d;
  logic [3:0]        dm_be_q, dm_be_d;
  logic [31:0]       dm_wdata_q, dm_wdata_d;
  logic              wb_valid_q, wb_valid_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic [4:0]        wb_addr_q, wb_addr_d;
  logic              wb_we_q, wb_we_d;
  logic              mis_q, mis_d;
  logic              berr_q, berr_d;
  logic [31:0]       exc_q, exc_d;

  // Decode of the incoming op
  logic w_in_lw, w_in_sw, w_in_lb, w_in_lbu, w_in_sb, w_in_mem, w_in_word_mis;
  assign w_in_lw       = (op == OP_LW);
  assign w_in_sw       = (op == OP_SW);
  assign w_in_lb       = (op == OP_LB);
  assign w_in_lbu      = (op == OP_LBU);
  assign w_in_sb       = (op == OP_SB);
  assign w_in_mem      = w_in_lw | w_in_sw | w_in_lb | w_in_lbu | w_in_sb;
  assign w_in_word_mis = (w_in_lw | w_in_sw) && (memAddr[1:0] != 2'b00);

  // Load data extraction for the captured transaction
  logic       w_q_store;
  logic [7:0] w_byte;
  logic [31:0] w_load_data;
  assign w_q_store = (op_q == OP_SW) || (op_q == OP_SB);

  always_comb begin
    w_byte = dm_rdata[7:0];
    case (addr_q[1:0])
      2'd0:    w_byte = dm_rdata[7:0];
      2'd1:    w_byte = dm_rdata[15:8];
      2'd2:    w_byte = dm_rdata[23:16];
      default: w_byte = dm_rdata[31:24];
    endcase
  end

  always_comb begin
    if (op_q == OP_LW)      w_load_data = dm_rdata;
    else if (op_q == OP_LB) w_load_data = {{24{w_byte[7]}}, w_byte};
    else                    w_load_data = {24'd0, w_byte};
  end

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    addr_d     = addr_q;
    rdst_d     = rdst_q;
    rwe_d      = rwe_q;
    dm_req_d   = dm_req_q;
    dm_we_d    = dm_we_q;
    dm_addr_d  = dm_addr_q;
    dm_be_d    = dm_be_q;
    dm_wdata_d = dm_wdata_q;
    wb_valid_d = 1'b0;
    wb_data_d  = wb_data_q;
    wb_addr_d  = wb_addr_q;
    wb_we_d    = wb_we_q;
    mis_d      = 1'b0;
    berr_d     = 1'b0;
    exc_d      = exc_q;

    case (state_q)
      S_IDLE: begin
        if (ex_valid) begin
          if (!w_in_mem) begin
            wb_valid_d = 1'b1;
            wb_data_d  = regcData;
            wb_addr_d  = regcAddr;
            wb_we_d    = regcWrite;
          end else if (w_in_word_mis) begin
            wb_valid_d = 1'b1;
            wb_data_d  = 32'd0;
            wb_addr_d  = regcAddr;
            wb_we_d    = 1'b0;
            mis_d      = 1'b1;
            exc_d      = memAddr;
          end else begin
            state_d    = S_BUSY;
            cnt_d      = '0;
            op_d       = op;
            addr_d     = memAddr;
            rdst_d     = regcAddr;
            rwe_d      = regcWrite;
            dm_req_d   = 1'b1;
            dm_we_d    = w_in_sw | w_in_sb;
            dm_addr_d  = {memAddr[31:2], 2'b00};
            dm_be_d    = w_in_sb ? (4'b0001 << memAddr[1:0]) : 4'b1111;
            dm_wdata_d = w_in_sw ? memData :
                         w_in_sb ? {4{memData[7:0]}} : 32'd0;
          end
        end
      end
      default: begin
        // Ack takes priority over the timeout in the final counted cycle.
        if (dm_ack || (cnt_q == C_CNT_LAST)) begin
          state_d    = S_IDLE;
          dm_req_d   = 1'b0;
          dm_we_d    = 1'b0;
          dm_addr_d  = 32'd0;
          dm_be_d    = 4'd0;
          dm_wdata_d = 32'd0;
          wb_valid_d = 1'b1;
          wb_addr_d  = rdst_q;
          if (dm_ack && !w_q_store) begin
            wb_data_d = w_load_data;
            wb_we_d   = rwe_q;
          end else begin
            wb_data_d = 32'd0;
            wb_we_d   = 1'b0;
          end
          if (!dm_ack) begin
            berr_d = 1'b1;
            exc_d  = addr_q;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= 6'd0;
      addr_q     <= 32'd0;
      rdst_q     <= 5'd0;
      rwe_q      <= 1'b0;
      dm_req_q   <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= 32'd0;
      dm_be_q    <= 4'd0;
      dm_wdata_q <= 32'd0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= 32'd0;
      wb_addr_q  <= 5'd0;
      wb_we_q    <= 1'b0;
      mis_q      <= 1'b0;
      berr_q     <= 1'b0;
      exc_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      rdst_q     <= rdst_d;
      rwe_q      <= rwe_d;
      dm_req_q   <= dm_req_d;
      dm_we_q    <= dm_we_d;
      dm_addr_q  <= dm_addr_d;
      dm_be_q    <= dm_be_d;
      dm_wdata_q <= dm_wdata_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_addr_q  <= wb_addr_d;
      wb_we_q    <= wb_we_d;
      mis_q      <= mis_d;
      berr_q     <= berr_d;
      exc_q      <= exc_d;
    end
  end

  assign stall_o      = (state_q == S_BUSY);
  assign dm_req       = dm_req_q;
  assign dm_we        = dm_we_q;
  assign dm_addr      = dm_addr_q;
  assign dm_be        = dm_be_q;
  assign dm_wdata     = dm_wdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_regcData  = wb_data_q;
  assign wb_regcAddr  = wb_addr_q;
  assign wb_regcWrite = wb_we_q;
  assign misalign_exc = mis_q;
  assign bus_err      = berr_q;
  assign exc_addr     = exc_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Scoreboard bench for mem_stage. Directed transactions push
//               their expected write-back bundle; a monitor pops and compares
//               on every wb_valid. A memory responder acks after a set number
//               of request cycles and records bus activity per transaction.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

  localparam logic [5:0] C_LW  = 6'b100011;
  localparam logic [5:0] C_SW  = 6'b101011;
  localparam logic [5:0] C_LB  = 6'b100000;
  localparam logic [5:0] C_LBU = 6'b100100;
  localparam logic [5:0] C_SB  = 6'b101000;
  localparam logic [5:0] C_ADD = 6'b000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic [5:0]  op = 6'd0;
  logic [31:0] memAddr = 32'd0, memData = 32'd0, regcData = 32'd0;
  logic [4:0]  regcAddr = 5'd0;
  logic        regcWrite = 1'b0;
  logic        stall_o, dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ack = 1'b0;
  logic [31:0] dm_rdata = 32'd0;
  logic        wb_valid, wb_regcWrite, misalign_exc, bus_err;
  logic [31:0] wb_regcData, exc_addr;
  logic [4:0]  wb_regcAddr;

  mem_stage dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .op(op), .memAddr(memAddr),
    .memData(memData), .regcData(regcData), .regcAddr(regcAddr),
    .regcWrite(regcWrite), .stall_o(stall_o), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_ack(dm_ack),
    .dm_rdata(dm_rdata), .wb_valid(wb_valid), .wb_regcData(wb_regcData),
    .wb_regcAddr(wb_regcAddr), .wb_regcWrite(wb_regcWrite),
    .misalign_exc(misalign_exc), .bus_err(bus_err), .exc_addr(exc_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  addr;
    logic        we;
    logic        mis;
    logic        berr;
    logic [31:0] exc;
    bit          chk_d;
    bit          chk_a;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  int n_pass = 0;
  int n_total = 0;
  int n_wb = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Memory responder and bus recorder
  int          rcnt = 0, req_total = 0, stall_total = 0, ack_wait = 1;
  bit          no_ack = 1'b0, unstable = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        cap_we;
  logic [31:0] cap_addr, cap_wd;
  logic [3:0]  cap_be;

  always @(negedge clk) begin
    if (dm_req === 1'b1) begin
      rcnt = rcnt + 1;
      req_total = req_total + 1;
      if (rcnt == 1) begin
        cap_we = dm_we; cap_addr = dm_addr; cap_be = dm_be; cap_wd = dm_wdata;
      end else if ({dm_we, dm_addr, dm_be, dm_wdata} !== {cap_we, cap_addr, cap_be, cap_wd}) begin
        unstable = 1'b1;
      end
      dm_ack   = !no_ack && (rcnt == ack_wait);
      dm_rdata = dm_ack ? mem_rdata : 32'd0;
    end else begin
      rcnt   = 0;
      dm_ack = 1'b0;
    end
    if (stall_o === 1'b1) stall_total = stall_total + 1;
  end

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (wb_valid === 1'b1) begin
        if (q.size() == 0) begin
          check("unexpected_wb", 32'd1, 32'd0);
        end else begin
          mon_e = q.pop_front();
          if (mon_e.chk_d) check("wb_regcData", wb_regcData, mon_e.data);
          if (mon_e.chk_a) check("wb_regcAddr", {27'd0, wb_regcAddr}, {27'd0, mon_e.addr});
          check("wb_regcWrite", {31'd0, wb_regcWrite}, {31'd0, mon_e.we});
          check("misalign_exc", {31'd0, misalign_exc}, {31'd0, mon_e.mis});
          check("bus_err", {31'd0, bus_err}, {31'd0, mon_e.berr});
          check("exc_addr", exc_addr, mon_e.exc);
          n_wb++;
        end
      end else if (misalign_exc !== 1'b0 || bus_err !== 1'b0) begin
        check("stray_exc", 32'd1, 32'd0);
      end
    end
  end

  task automatic txn(input string nm, input logic [5:0] op_v, input logic [31:0] addr_v,
                     input logic [31:0] mdata_v, input logic [31:0] regc_v,
                     input logic [4:0] ra_v, input logic rw_v, input logic [31:0] rdata_v,
                     input int wait_v, input bit noack_v, input int exp_req,
                     input logic e_we, input logic [3:0] e_be, input logic [31:0] e_daddr,
                     input logic [31:0] e_wdata, input exp_t e);
    int start;
    int guard;
    q.push_back(e);
    start = n_wb;
    req_total = 0; stall_total = 0; unstable = 1'b0;
    ack_wait = wait_v; no_ack = noack_v; mem_rdata = rdata_v;
    ex_valid = 1'b1; op = op_v; memAddr = addr_v; memData = mdata_v;
    regcData = regc_v; regcAddr = ra_v; regcWrite = rw_v;
    @(negedge clk); #1;
    ex_valid = 1'b0;
    guard = 0;
    while (n_wb == start && guard < 60) begin
      @(negedge clk); #1;
      guard++;
    end
    if (n_wb == start) check({nm, "_wb_missing"}, 32'd0, 32'd1);
    check({nm, "_latency"}, guard, exp_req);
    check({nm, "_req_cycles"}, req_total, exp_req);
    check({nm, "_stall_cycles"}, stall_total, exp_req);
    if (exp_req > 0) begin
      check({nm, "_dm_we"}, {31'd0, cap_we}, {31'd0, e_we});
      check({nm, "_dm_addr"}, cap_addr, e_daddr);
      check({nm, "_dm_be"}, {28'd0, cap_be}, {28'd0, e_be});
      check({nm, "_dm_wdata"}, cap_wd, e_wdata);
      check({nm, "_bus_stable"}, {31'd0, unstable}, 32'd0);
    end
  endtask

  initial begin
    int guard;
    #200000;
    $display("FAIL watchdog: got hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    repeat (3) @(negedge clk);
    #1;
    check("rst_dm_req", {31'd0, dm_req}, 32'd0);
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_misalign", {31'd0, misalign_exc}, 32'd0);
    check("rst_bus_err", {31'd0, bus_err}, 32'd0);
    check("rst_exc_addr", exc_addr, 32'd0);
    check("rst_wb_data", wb_regcData, 32'd0);
    check("rst_dm_be", {28'd0, dm_be}, 32'd0);
    rst = 1'b0;
    @(negedge clk); #1;

    //   name        op     addr        mdata         regc          ra  rw  rdata         wait noack req we  be    daddr       wdata
    txn("alu",  C_ADD, 32'h0000_0000, 32'h0, 32'h0000_1234, 5'd5, 1'b1, 32'h0, 1, 1'b0, 0, 1'b0, 4'h0, 32'h0, 32'h0,
        '{32'h0000_1234, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1});
    txn("lw0",  C_LW,  32'h0000_0100, 32'h1111_2222, 32'hCAFE_0000, 5'd8, 1'b1, 32'hDEAD_BEEF, 1, 1'b0, 1, 1'b0, 4'hF, 32'h100, 32'h0,
        '{32'hDEAD_BEEF, 5'd8, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1});
    txn("lb3",  C_LB,  32'h0000_0103, 32'h0, 32'hCAFE_0000, 5'd9, 1'b1, 32'h8012_3456, 1, 1'b0, 1, 1'b0, 4'hF, 32'h100, 32'h0,
        '{32'hFFFF_FF80, 5'd9, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1});
    txn("lbu3", C_LBU, 32'h0000_0103, 32'h0, 32'hCAFE_0000, 5'd10, 1'b1, 32'h8012_3456, 1, 1'b0, 1, 1'b0, 4'hF, 32'h100, 32'h0,
        '{32'h0000_0080, 5'd10, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1});
    txn("lb1",  C_LB,  32'h0000_0101, 32'h0, 32'hCAFE_0000, 5'd11, 1'b1, 32'h1234_7F56, 2, 1'b0, 2, 1'b0, 4'hF, 32'h100, 32'h0,
        '{32'h0000_007F, 5'd11, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1});
    txn("lbu0", C_LBU, 32'h0000_0100, 32'h0, 32'hCAFE_0000, 5'd12, 1'b1, 32'h1234_56FE, 1, 1'b0, 1, 1'b0, 4'hF, 32'h100, 32'h0,
        '{32'h0000_00FE, 5'd12, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1});
    txn("lb2",  C_LB,  32'h0000_0102, 32'h0, 32'hCAFE_0000, 5'd13, 1'b1, 32'h00F5_0000, 1, 1'b0, 1, 1'b0, 4'hF, 32'h100, 32'h0,
        '{32'hFFFF_FFF5, 5'd13, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1});
    txn("sb2",  C_SB,  32'h0000_0102, 32'h0000_0055, 32'hCAFE_0000, 5'd14, 1'b1, 32'h0, 1, 1'b0, 1, 1'b1, 4'b0100, 32'h100, 32'h5555_5555,
        '{32'h0, 5'd14, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0});
    txn("sw_mis", C_SW, 32'h0000_0102, 32'h1234_5678, 32'hCAFE_0000, 5'd0, 1'b1, 32'h0, 1, 1'b0, 0, 1'b0, 4'h0, 32'h0, 32'h0,
        '{32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h0000_0102, 1'b0, 1'b0});
    txn("sw_w3", C_SW, 32'h0000_0204, 32'hA5A5_1234, 32'hCAFE_0000, 5'd0, 1'b1, 32'h0, 3, 1'b0, 3, 1'b1, 4'hF, 32'h204, 32'hA5A5_1234,
        '{32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0102, 1'b1, 1'b0});
    txn("lw_w3", C_LW, 32'h0000_0200, 32'h0, 32'hCAFE_0000, 5'd15, 1'b1, 32'h0BAD_F00D, 3, 1'b0, 3, 1'b0, 4'hF, 32'h200, 32'h0,
        '{32'h0BAD_F00D, 5'd15, 1'b1, 1'b0, 1'b0, 32'h0000_0102, 1'b1, 1'b1});
    txn("lw_tmo", C_LW, 32'h0000_0304, 32'h0, 32'hCAFE_0000, 5'd16, 1'b1, 32'h0, 0, 1'b1, 16, 1'b0, 4'hF, 32'h304, 32'h0,
        '{32'h0, 5'd16, 1'b0, 1'b0, 1'b1, 32'h0000_0304, 1'b0, 1'b0});
    txn("lw_w16", C_LW, 32'h0000_0308, 32'h0, 32'hCAFE_0000, 5'd17, 1'b1, 32'h1357_9BDF, 16, 1'b0, 16, 1'b0, 4'hF, 32'h308, 32'h0,
        '{32'h1357_9BDF, 5'd17, 1'b1, 1'b0, 1'b0, 32'h0000_0304, 1'b1, 1'b1});
    txn("lw_mis", C_LW, 32'h0000_0201, 32'h0, 32'hCAFE_0000, 5'd18, 1'b1, 32'h0, 1, 1'b0, 0, 1'b0, 4'h0, 32'h0, 32'h0,
        '{32'h0, 5'd18, 1'b0, 1'b1, 1'b0, 32'h0000_0201, 1'b0, 1'b0});

    // Reset in the second BUSY cycle abandons the transaction silently.
    no_ack = 1'b1; req_total = 0;
    ex_valid = 1'b1; op = C_LW; memAddr = 32'h0000_0500; regcAddr = 5'd19; regcWrite = 1'b1;
    @(negedge clk); #1;
    ex_valid = 1'b0;
    guard = 0;
    while (req_total < 2 && guard < 20) begin
      @(negedge clk); #1;
      guard++;
    end
    check("rstmid_reached_busy2", req_total, 2);
    rst = 1'b1;
    @(negedge clk); #1;
    check("rstmid_dm_req", {31'd0, dm_req}, 32'd0);
    check("rstmid_stall", {31'd0, stall_o}, 32'd0);
    check("rstmid_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rstmid_exc_addr", exc_addr, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    txn("lw_post", C_LW, 32'h0000_0400, 32'h0, 32'hCAFE_0000, 5'd20, 1'b1, 32'h2468_ACE0, 1, 1'b0, 1, 1'b0, 4'hF, 32'h400, 32'h0,
        '{32'h2468_ACE0, 5'd20, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1});

    repeat (3) @(negedge clk);
    #1;
    check("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage of the MIPS core.
- Consumes the execute stage's op code, memory address, store data and ALU result. Performs lw/sw/lb/lbu/sb over a req/ack data-memory bus, with alignment checking and a timeout.
- Produces a registered write-back bundle for the register file.
- Stalls upstream while a bus transaction is outstanding.

Parameters:
- OP_LW, 6'b100011, load-word op code; must equal def.v op_lw.
- OP_SW, 6'b101011, store-word op code; must equal def.v op_sw.
- OP_LB, 6'b100000, load-byte signed op code; must equal def.v op_lb.
- OP_LBU, 6'b100100, load-byte unsigned op code; must equal def.v op_lbu.
- OP_SB, 6'b101000, store-byte op code; must equal def.v op_sb.
- TIMEOUT, 16, maximum number of BUSY cycles waiting for dm_ack before a bus error.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- ex_valid  in  1  execute-stage bundle valid this cycle.
- op  in  6  op code from the execute stage.
- memAddr  in  32  byte address from the execute stage.
- memData  in  32  store data from the execute stage.
- regcData  in  32  ALU result from the execute stage.
- regcAddr  in  5  destination register.
- regcWrite  in  1  destination write enable.
- stall_o  out  1  upstream must hold its bundle.
- dm_req  out  1  data-memory request.
- dm_we  out  1  1 = write.
- dm_addr  out  32  word-aligned address, {memAddr[31:2],2'b00}.
- dm_be  out  4  byte enables; bit i = byte lane i (little-endian).
- dm_wdata  out  32  write data.
- dm_ack  in  1  memory completion; for reads, dm_rdata is valid in the same cycle.
- dm_rdata  in  32  read data.
- wb_valid  out  1  write-back bundle valid (1-cycle pulse).
- wb_regcData  out  32  write-back data.
- wb_regcAddr  out  5  write-back register.
- wb_regcWrite  out  1  write-back enable.
- misalign_exc  out  1  1-cycle pulse: misaligned lw/sw.
- bus_err  out  1  1-cycle pulse: dm_ack timeout.
- exc_addr  out  32  faulting byte address; valid with either pulse, holds until the next fault.

Behaviour:
Reset:
- All outputs 0, state IDLE, timeout counter 0.
- Reset mid-transaction: dm_req drops at that edge. The transaction is abandoned, with no wb_valid and no error pulse.

States:
- IDLE:
  - stall_o=0.
  - Each cycle with ex_valid=1, the bundle is sampled.
  - Non-memory op: next cycle wb_valid=1, wb_* = regcData/regcAddr/regcWrite. Latency 1.
  - lw/sw with memAddr[1:0]!=0: no bus request. Next cycle misalign_exc=1, exc_addr=memAddr, wb_valid=1, wb_regcWrite=0. Stay IDLE.
  - Otherwise (aligned lw/sw, or any lb/lbu/sb): capture op, addr, data and regc fields; next state BUSY.
- BUSY:
  - stall_o=1 combinationally. ex_* inputs are ignored.
  - dm_req=1 and dm_we/dm_addr/dm_be/dm_wdata are registered and stable for the whole BUSY period.
  - dm_ack=1: next state IDLE. Next cycle wb_valid=1.
    - Loads: wb_regcData = extracted load data, wb_regcWrite = captured regcWrite.
    - Stores: wb_regcWrite=0, wb_regcData=0.
  - No ack after TIMEOUT BUSY cycles (counter reaches TIMEOUT-1 with dm_ack=0): next state IDLE. Next cycle bus_err=1, exc_addr=captured address, wb_valid=1, wb_regcWrite=0.
  - dm_ack arriving in the final counted cycle wins over the timeout.
  - dm_ack is ignored outside BUSY.
- dm_req is 0 in the cycle after leaving BUSY. A zero-wait memory (ack in the first BUSY cycle) gives BUSY of exactly 1 cycle.
- Throughput: one idle bubble follows each bus transaction, because stall_o is still 1 in the ack cycle.

Lane rules (k = addr[1:0]):
- lw/sw: dm_be=4'b1111, dm_wdata=memData.
- sb: dm_be = 4'b0001<<k, dm_wdata = {4{memData[7:0]}}.
- lb/lbu: dm_be=4'b1111. Byte = dm_rdata[8k+7:8k]; lb sign-extends to 32 bits, lbu zero-extends.
- Non-store transactions: dm_we=0, dm_wdata=0.

Other rules:
- wb_regcAddr=0 with write enable is passed through unchanged; the register file discards it.
- wb_*, misalign_exc and bus_err are registered outputs. wb_* hold their last values, wb_valid=0 when no pulse.

Test Plan:
- ALU pass-through: ex_valid=1, op=add-code, regcData=32'h0000_1234, regcAddr=5, regcWrite=1 -> next cycle wb_valid=1, wb_regcData=32'h1234, wb_regcAddr=5; dm_req never asserted.
- lw with zero-wait ack: memAddr=32'h100, dm_rdata=32'hDEAD_BEEF -> dm_req=1 with dm_addr=32'h100, dm_be=4'hF for 1 cycle; stall_o=1 for 1 cycle; wb_regcData=32'hDEAD_BEEF one cycle after ack.
- lb/lbu lane and sign: memAddr=32'h103, dm_rdata=32'h80xx_xxxx -> lb gives 32'hFFFF_FF80, lbu gives 32'h0000_0080. sb at 32'h102 with memData=32'h55 -> dm_be=4'b0100, dm_wdata=32'h5555_5555, dm_we=1, wb_regcWrite=0.
- Misaligned sw: memAddr=32'h102 -> no dm_req; next cycle misalign_exc=1, exc_addr=32'h102, wb_regcWrite=0.
- Wait states and timeout: ack after 3 BUSY cycles -> dm_req stable 3 cycles, stall_o=1 for 3 cycles. No ack -> exactly 16 BUSY cycles, then bus_err=1 and exc_addr=captured address; an ack in cycle 16 completes normally instead.
- Reset mid-BUSY: rst=1 at BUSY cycle 2 -> dm_req=0, stall_o=0, wb_valid=0 next cycle; a following lw after reset completes normally.
